// File: rtl/ct_ct_addsub_pipe.sv
// ct_ct_addsub_pipe: 2-stage lane-parallel modular add/sub of two ciphertexts.
// Optional subtract path (ct1 - ct2) is built when CT_ADDSUB_SUB_EN is defined.
package ct_addsub_pkg;
    localparam int N_SLOTS_L = 8;
    localparam int W_BITS_L  = 16;
    localparam int Q_MOD_L   = 97;
endpackage

module ct_ct_addsub_pipe
    import ct_addsub_pkg::*;
#(
    parameter int           N     = N_SLOTS_L,
    parameter int           W     = W_BITS_L,
    parameter logic [W-1:0] QP    = W'(Q_MOD_L),
    parameter int           LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_op,
    input  logic [LANES*W-1:0] in_x,
    input  logic [LANES*W-1:0] in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_z,
    output logic               out_comp,
    output logic               out_last
);
    localparam int BEATS = 2 * N / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(BEATS - 1);
    localparam logic [CW-1:0] HALF_C = CW'(N / LANES);
    localparam logic [W:0]    Q1     = {1'b0, QP};

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  v1_q, v1_d;
    logic                  comp1_q, comp1_d;
    logic                  last1_q, last1_d;
    logic [LANES-1:0][W:0] r1_q, r1_d;
    logic [LANES-1:0]      f1_q, f1_d;
    logic                  v2_q, v2_d;
    logic                  comp2_q, comp2_d;
    logic                  last2_q, last2_d;
    logic [LANES*W-1:0]    z2_q, z2_d;
    logic                  advance;
    logic                  accept;

`ifdef CT_ADDSUB_SUB_EN
    logic op_q, op_d;
    logic op1_q, op1_d;
    logic op_cur;
`else
    logic unused_op;
    assign unused_op = in_op;
`endif

    assign advance   = !v2_q || out_ready;
    assign accept    = in_valid && advance;
    assign in_ready  = advance;
    assign out_valid = v2_q;
    assign out_z     = z2_q;
    assign out_comp  = comp2_q;
    assign out_last  = last2_q;

`ifdef CT_ADDSUB_SUB_EN
    // op is used live on the first beat, latched for the rest of the ciphertext
    assign op_cur = (cnt_q == '0) ? in_op : op_q;

    always_comb begin
        op_d  = op_q;
        op1_d = op1_q;
        if (accept && cnt_q == '0) op_d = in_op;
        if (advance) op1_d = op_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= 1'b0;
            op1_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            op1_q <= op1_d;
        end
    end
`endif

    always_comb begin
        cnt_d   = cnt_q;
        v1_d    = v1_q;
        comp1_d = comp1_q;
        last1_d = last1_q;
        r1_d    = r1_q;
        f1_d    = f1_q;
        if (accept) cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
        if (advance) begin
            v1_d    = accept;
            comp1_d = cnt_q >= HALF_C;
            last1_d = cnt_q == LAST_C;
            for (int k = 0; k < LANES; k++) begin
`ifdef CT_ADDSUB_SUB_EN
                if (op_cur) begin
                    r1_d[k] = {1'b0, in_x[k*W +: W] - in_y[k*W +: W]};
                    f1_d[k] = in_x[k*W +: W] < in_y[k*W +: W];
                end else
`endif
                begin
                    r1_d[k] = {1'b0, in_x[k*W +: W]} + {1'b0, in_y[k*W +: W]};
                    f1_d[k] = r1_d[k] >= Q1;
                end
            end
        end
    end

    always_comb begin
        v2_d    = v2_q;
        comp2_d = comp2_q;
        last2_d = last2_q;
        z2_d    = z2_q;
        if (advance) begin
            v2_d    = v1_q;
            comp2_d = comp1_q;
            last2_d = last1_q;
            for (int k = 0; k < LANES; k++) begin
`ifdef CT_ADDSUB_SUB_EN
                if (op1_q) begin
                    z2_d[k*W +: W] = f1_q[k] ? r1_q[k][W-1:0] + QP
                                             : r1_q[k][W-1:0];
                end else
`endif
                begin
                    z2_d[k*W +: W] = f1_q[k] ? W'(r1_q[k] - Q1)
                                             : r1_q[k][W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            comp1_q <= 1'b0;
            last1_q <= 1'b0;
            r1_q    <= '0;
            f1_q    <= '0;
            v2_q    <= 1'b0;
            comp2_q <= 1'b0;
            last2_q <= 1'b0;
            z2_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            comp1_q <= comp1_d;
            last1_q <= last1_d;
            r1_q    <= r1_d;
            f1_q    <= f1_d;
            v2_q    <= v2_d;
            comp2_q <= comp2_d;
            last2_q <= last2_d;
            z2_q    <= z2_d;
        end
    end
endmodule

// File: tb/tb_ct_ct_addsub_pipe.sv
// tb_ct_ct_addsub_pipe: directed checks of ct_ct_addsub_pipe, N=8 LANES=4 W=16 q=97.
// Expected subtract results apply when CT_ADDSUB_SUB_EN is defined.
module tb_ct_ct_addsub_pipe;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [63:0] in_x;
    logic [63:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_z;
    logic        out_comp;
    logic        out_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] bx[8], by[8], bz[8];
    logic        bop[8], bc[8], bl[8];

    ct_ct_addsub_pipe #(
        .N(8), .W(16), .QP(16'd97), .LANES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_x(in_x),
        .in_y(in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z(out_z),
        .out_comp(out_comp),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary by time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_oz", out_z, 64'd0);
        chk("rst_oc", {63'd0, out_comp}, 64'd0);
        chk("rst_ol", {63'd0, out_last}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_inrdy", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_beats(input int n, input string nm);
        for (int cyc = 0; cyc < n + 2; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                chk($sformatf("%s_v%0d", nm, cyc - 2),
                    {63'd0, out_valid}, 64'd1);
                chk($sformatf("%s_z%0d", nm, cyc - 2), out_z, bz[cyc-2]);
                chk($sformatf("%s_c%0d", nm, cyc - 2),
                    {63'd0, out_comp}, {63'd0, bc[cyc-2]});
                chk($sformatf("%s_l%0d", nm, cyc - 2),
                    {63'd0, out_last}, {63'd0, bl[cyc-2]});
            end
            if (cyc < n) begin
                in_valid = 1'b1;
                in_op = bop[cyc];
                in_x = bx[cyc];
                in_y = by[cyc];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk({nm, "_idle"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int snd;
        int rcv;
        int stalls;
        logic held;
        logic [65:0] hv;
        logic [63:0] ez;

        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b1;

        do_reset();

        // latency: accepted beat appears exactly two cycles later
        in_valid = 1'b1;
        in_op = 1'b0;
        in_x = pk(60, 0, 0, 0);
        in_y = pk(50, 0, 0, 0);
        #1;
        chk("lat_inrdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_c2", {63'd0, out_valid}, 64'd1);
        chk("lat_z", out_z, pk(13, 0, 0, 0));
        chk("lat_comp", {63'd0, out_comp}, 64'd0);
        @(negedge clk);
        chk("lat_c3", {63'd0, out_valid}, 64'd0);

        // framing, op toggled on beat 2 has no effect
        do_reset();
        bx[0] = pk(60, 96, 0, 10); by[0] = pk(50, 1, 0, 20);
        bz[0] = pk(13, 0, 0, 30);
        bx[1] = pk(96, 50, 5, 9);  by[1] = pk(96, 46, 9, 5);
        bz[1] = pk(95, 96, 14, 14);
        bx[2] = pk(1, 2, 3, 4);    by[2] = pk(5, 6, 7, 8);
        bz[2] = pk(6, 8, 10, 12);
        bx[3] = pk(48, 49, 0, 0);  by[3] = pk(48, 48, 97, 100);
        bz[3] = pk(96, 0, 0, 3);
        bop[0] = 0; bop[1] = 1; bop[2] = 0; bop[3] = 0;
        bc[0] = 0; bc[1] = 0; bc[2] = 1; bc[3] = 1;
        bl[0] = 0; bl[1] = 0; bl[2] = 0; bl[3] = 1;
        run_beats(4, "frm");

        // next ciphertext after wrap: op sampled at counter 0 only
        bx[0] = pk(5, 9, 0, 96);   by[0] = pk(9, 5, 96, 0);
        bx[1] = pk(10, 0, 200, 7); by[1] = pk(3, 1, 0, 7);
`ifdef CT_ADDSUB_SUB_EN
        bz[0] = pk(93, 4, 1, 96);
        bz[1] = pk(7, 96, 200, 0);
`else
        bz[0] = pk(14, 14, 96, 96);
        bz[1] = pk(13, 1, 103, 14);
`endif
        bop[0] = 1; bop[1] = 0;
        bc[0] = 0; bc[1] = 0;
        bl[0] = 0; bl[1] = 0;
        run_beats(2, "op");

        // backpressure: out_ready low 3 cycles, in_valid continuous
        do_reset();
        snd = 0;
        rcv = 0;
        stalls = 0;
        held = 1'b0;
        hv = '0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c < 7);
            in_valid = snd < 6;
            in_op = 1'b0;
            in_x = pk(90 + snd, 90 + snd, 90 + snd, 90 + snd);
            in_y = pk(5, 6, 7, 8);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("bp_inrdy", {63'd0, in_ready}, 64'd0);
                if (held)
                    chk("bp_hold", hv[63:0] ^ out_z ^
                        {62'd0, hv[65:64] ^ {out_comp, out_last}},
                        64'd0);
                held = 1'b1;
                hv = {out_comp, out_last, out_z};
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                ez = pk((95 + rcv) % 97, (96 + rcv) % 97,
                        (97 + rcv) % 97, (98 + rcv) % 97);
                chk($sformatf("bp_z%0d", rcv), out_z, ez);
                chk($sformatf("bp_c%0d", rcv), {63'd0, out_comp},
                    {63'd0, (rcv % 4) >= 2});
                chk($sformatf("bp_l%0d", rcv), {63'd0, out_last},
                    {63'd0, (rcv % 4) == 3});
                rcv++;
            end
            if (in_valid && in_ready) snd++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(rcv), 64'd6);
        chk("bp_stalled", 64'(stalls), 64'd3);
        @(negedge clk);
        @(negedge clk);
        chk("bp_nodup", {63'd0, out_valid}, 64'd0);

        // reset mid-ciphertext
        do_reset();
        in_valid = 1'b1;
        in_op = 1'b0;
        in_x = pk(1, 2, 3, 4);
        in_y = pk(1, 1, 1, 1);
        @(negedge clk);
        in_x = pk(10, 20, 30, 40);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_pre_v", {63'd0, out_valid}, 64'd1);
        chk("mr_pre_z", out_z, pk(2, 3, 4, 5));
        reset = 1'b1;
        #1;
        chk("mr_v", {63'd0, out_valid}, 64'd0);
        chk("mr_z", out_z, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        in_x = pk(7, 7, 7, 7);
        in_y = pk(95, 0, 90, 96);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_flush", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("mr_nv", {63'd0, out_valid}, 64'd1);
        chk("mr_nz", out_z, pk(5, 7, 0, 6));
        chk("mr_ncomp", {63'd0, out_comp}, 64'd0);
        chk("mr_nlast", {63'd0, out_last}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ct_ct_addsub_pipe.md
CT_CT_ADDSUB_PIPE -- requirements
Module: ct_ct_addsub_pipe

Interface
REQ-001 SHALL have parameter N, default N_SLOTS_L, coefficients per polynomial.
REQ-002 SHALL have parameter W, default W_BITS_L, coefficient width in bits.
REQ-003 SHALL have parameter QP, default Q_MOD_L, W-bit modulus q.
REQ-004 SHALL have parameter LANES, default 4, coefficients per beat; N SHALL be a multiple of LANES.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, input beat valid.
REQ-008 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_op, input, 1, 0 = add, 1 = subtract (ct1 - ct2).
REQ-010 SHALL have port in_x, input, LANES*W, ct1 coefficients; lane k in bits [k*W +: W].
REQ-011 SHALL have port in_y, input, LANES*W, ct2 coefficients, same lane packing.
REQ-012 SHALL have port out_valid, output, 1, result beat valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.
REQ-014 SHALL have port out_z, output, LANES*W, result coefficients, same lane packing.
REQ-015 SHALL have port out_comp, output, 1, 0 = beat belongs to component A, 1 = component B.
REQ-016 SHALL have port out_last, output, 1, final beat of a ciphertext.

Function
REQ-017 SHALL treat one ciphertext as 2*N/LANES beats: N/LANES beats of A, then N/LANES beats of B.
REQ-018 SHALL keep an input beat counter of range 0 .. 2*N/LANES-1; it increments on each accepted beat and wraps to 0 after the last beat.
REQ-019 SHALL sample in_op only on the beat accepted at counter 0 and apply that op to every beat of the ciphertext; in_op changes on other beats are ignored.
REQ-020 SHALL compute, per lane, for add: s = a + b in W+1 bits; result = s - q if s >= q, else s.
REQ-021 SHALL compute, per lane, for subtract: d = a - b; result = d + q if a < b, else d, truncated to W bits.
REQ-022 SHALL apply a single conditional correction only; operands >= q produce that formula result, with no error flag.
REQ-023 SHALL be a 2-stage pipeline: stage 1 registers raw sum/difference plus borrow/compare flags; stage 2 registers the corrected result, out_comp and out_last.
REQ-024 SHALL produce out_valid 2 cycles after acceptance when out_ready is held high, at a throughput of 1 beat per cycle.
REQ-025 SHALL advance the whole pipeline iff (stage 2 empty or out_ready high); in_ready SHALL equal that advance condition, combinationally.
REQ-026 SHALL hold out_z, out_comp and out_last stable while out_valid is high and out_ready is low; it SHALL never drop or duplicate a beat.
REQ-027 SHALL set out_comp = 1 when the beat's counter is >= N/LANES, and out_last = 1 when the counter equals 2*N/LANES-1.
REQ-028 SHALL process independent lanes with no cross-lane carry.

Reset
REQ-029 SHALL, while reset is high, asynchronously clear out_valid, both stage valids, the beat counter and the latched op to 0.
REQ-030 SHALL clear out_z, out_comp and out_last to 0 on reset.
REQ-031 SHALL, on reset mid-ciphertext, discard the partial ciphertext; the first beat accepted after reset starts a new ciphertext at counter 0.
REQ-032 SHALL hold in_ready = 1 after reset.

Configuration
REQ-033 SHALL implement the subtract path when macro CT_ADDSUB_SUB_EN is defined.
REQ-034 SHALL, with CT_ADDSUB_SUB_EN undefined, ignore in_op, always add, and synthesise no subtract logic; port list is unchanged.

Verification (N=8, LANES=4, W=16, QP=97)
REQ-035 SHALL verify add: x lane0 = 60, y lane0 = 50, op = 0, out_ready = 1 -> out_z lane0 = 13, exactly 2 cycles after acceptance.
REQ-036 SHALL verify subtract with macro defined: x = 5, y = 9, op = 1 -> 93; x = 9, y = 5 -> 4.
REQ-037 SHALL verify framing: 4 back-to-back beats -> out_comp sequence 0,0,1,1 and out_last only on beat 4; op toggled on beat 2 -> no effect on results.
REQ-038 SHALL verify backpressure: out_ready low for 3 cycles with continuous in_valid -> in_ready low while stage 2 is full, outputs stable, all beats delivered in order exactly once.
REQ-039 SHALL verify reset mid-operation: assert reset after beat 2 -> out_valid = 0 immediately; the next beat has out_comp = 0 and counter restarted.
REQ-040 SHALL verify macro undefined: op = 1, x = 5, y = 9 -> 14.
